// File: rtl/hazard_ctrl.sv
// hazard_ctrl
// Pipeline hazard controller for the 5-stage core.
//   - EX-stage operand forwarding selects, one 2-bit field per source slot
//     (00 regfile, 01 WB, 10 MEM; MEM has priority, x0 is never forwarded)
//   - decode load-use detection (stall PC and IF/ID, bubble into ID/EX)
//   - stall sequencing for a multi-cycle MDU op resident in EX
//   - flushes on a control-flow redirect resolved in EX
// Priority: MDU stall > redirect > load-use.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   src_reg_id / src_valid_id     decode source indices / read-valid bits
//   src_reg_ex                    EX source indices (same packing)
//   reg_dest_ex, mem_read_ex      EX destination, EX is a load
//   mdu_start_ex, pc_src_ex       EX is an MDU op, EX redirects the PC
//   reg_dest_mem/wb, reg_write_mem/wb  later-stage destinations and enables
//   forward_sel                   per-slot select at [2k +: 2]
//   stall_f/d/e, flush_d/e/m      pipeline register enables / clears
//   mdu_done                      final EX cycle of an MDU op
//   stall_cycles, redirect_count  saturating performance counters
//
// Build option: define HAZARD_CTRL_PERF_EN to implement the performance
// counters; otherwise both counter outputs are tied to zero.
module hazard_ctrl #(
  parameter int REG_ADDR_W  = 5,
  parameter int NUM_SRC     = 2,
  parameter int MDU_LATENCY = 4,
  parameter int CNT_W       = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] src_reg_id,
  input  logic [NUM_SRC-1:0]            src_valid_id,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] src_reg_ex,
  input  logic [REG_ADDR_W-1:0]         reg_dest_ex,
  input  logic                          mem_read_ex,
  input  logic                          mdu_start_ex,
  input  logic                          pc_src_ex,
  input  logic [REG_ADDR_W-1:0]         reg_dest_mem,
  input  logic [REG_ADDR_W-1:0]         reg_dest_wb,
  input  logic                          reg_write_mem,
  input  logic                          reg_write_wb,
  output logic [2*NUM_SRC-1:0]          forward_sel,
  output logic                          stall_f,
  output logic                          stall_d,
  output logic                          stall_e,
  output logic                          flush_d,
  output logic                          flush_e,
  output logic                          flush_m,
  output logic                          mdu_done,
  output logic [CNT_W-1:0]              stall_cycles,
  output logic [CNT_W-1:0]              redirect_count
);

  localparam int CNT_BITS = $clog2(MDU_LATENCY) + 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  logic [0:0]          state_q, state_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic                mdu_stall;
  logic                mdu_done_c;
  logic [2*NUM_SRC-1:0] fwd_c;
  logic [NUM_SRC-1:0]  lu_match;
  logic                load_use;

  // Per-slot forwarding and load-use compare
  generate
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_slot
      logic [REG_ADDR_W-1:0] s_ex;
      logic [REG_ADDR_W-1:0] s_id;
      logic                  mem_hit;
      logic                  wb_hit;

      assign s_ex    = src_reg_ex[gi*REG_ADDR_W +: REG_ADDR_W];
      assign s_id    = src_reg_id[gi*REG_ADDR_W +: REG_ADDR_W];
      assign mem_hit = reg_write_mem && (s_ex == reg_dest_mem) && (s_ex != '0);
      assign wb_hit  = reg_write_wb  && (s_ex == reg_dest_wb)  && (s_ex != '0);
      assign fwd_c[2*gi +: 2] = mem_hit ? 2'b10 : (wb_hit ? 2'b01 : 2'b00);
      assign lu_match[gi] = src_valid_id[gi] && (s_id == reg_dest_ex);
    end
  endgenerate

  assign load_use = mem_read_ex && (reg_dest_ex != '0) && (|lu_match);

  // MDU sequencer: the op sits in EX for MDU_LATENCY cycles and the pipe is
  // held for all but the last one. A start seen while BUSY is the same held
  // instruction, so it is ignored.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mdu_stall  = 1'b0;
    mdu_done_c = 1'b0;
    if (MDU_LATENCY == 1) begin
      mdu_done_c = mdu_start_ex;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (mdu_start_ex) begin
            mdu_stall = 1'b1;
            cnt_d     = CNT_BITS'(MDU_LATENCY - 1);
            state_d   = ST_BUSY;
          end
        end
        default: begin
          if (cnt_q > CNT_BITS'(1)) begin
            mdu_stall = 1'b1;
            cnt_d     = cnt_q - CNT_BITS'(1);
          end else begin
            mdu_done_c = 1'b1;
            cnt_d      = '0;
            state_d    = ST_IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Output arbitration; everything is forced quiet while in reset.
  always_comb begin
    forward_sel = '0;
    stall_f     = 1'b0;
    stall_d     = 1'b0;
    stall_e     = 1'b0;
    flush_d     = 1'b0;
    flush_e     = 1'b0;
    flush_m     = 1'b0;
    mdu_done    = 1'b0;
    if (!rst) begin
      forward_sel = fwd_c;
      mdu_done    = mdu_done_c;
      if (mdu_stall) begin
        // Hold the MDU op in EX; never flush it away.
        stall_f = 1'b1;
        stall_d = 1'b1;
        stall_e = 1'b1;
        flush_m = 1'b1;
      end else if (pc_src_ex) begin
        flush_d = 1'b1;
        flush_e = 1'b1;
      end else if (load_use) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        flush_e = 1'b1;
      end
    end
  end

`ifdef HAZARD_CTRL_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] redir_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      redir_cnt_q <= '0;
    end else begin
      if (stall_f && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      if (pc_src_ex && !mdu_stall && (redir_cnt_q != '1)) begin
        redir_cnt_q <= redir_cnt_q + CNT_W'(1);
      end
    end
  end

  assign stall_cycles   = stall_cnt_q;
  assign redirect_count = redir_cnt_q;
`else
  assign stall_cycles   = '0;
  assign redirect_count = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl. Main instance uses MDU_LATENCY=4 and
// CNT_W=4; a second instance with MDU_LATENCY=1 shares the inputs.
module tb_hazard_ctrl;

  localparam int RW = 5;
  localparam int NS = 2;
  localparam int CW = 4;

`ifdef HAZARD_CTRL_PERF_EN
  localparam logic [31:0] EXP_STALL10 = 32'd10;
  localparam logic [31:0] EXP_STALL   = 32'd15;
  localparam logic [31:0] EXP_REDIR   = 32'd1;
`else
  localparam logic [31:0] EXP_STALL10 = 32'd0;
  localparam logic [31:0] EXP_STALL   = 32'd0;
  localparam logic [31:0] EXP_REDIR   = 32'd0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [NS*RW-1:0]  src_reg_id;
  logic [NS-1:0]     src_valid_id;
  logic [NS*RW-1:0]  src_reg_ex;
  logic [RW-1:0]     reg_dest_ex;
  logic              mem_read_ex;
  logic              mdu_start_ex;
  logic              pc_src_ex;
  logic [RW-1:0]     reg_dest_mem;
  logic [RW-1:0]     reg_dest_wb;
  logic              reg_write_mem;
  logic              reg_write_wb;

  logic [2*NS-1:0]   forward_sel, forward_sel1;
  logic              stall_f, stall_d, stall_e, flush_d, flush_e, flush_m, mdu_done;
  logic              stall_f1, stall_d1, stall_e1, flush_d1, flush_e1, flush_m1, mdu_done1;
  logic [CW-1:0]     stall_cycles, redirect_count, stall_cycles1, redirect_count1;

  // {stall_f, stall_d, stall_e, flush_d, flush_e, flush_m, mdu_done}
  logic [6:0] ctl, ctl1;
  assign ctl  = {stall_f, stall_d, stall_e, flush_d, flush_e, flush_m, mdu_done};
  assign ctl1 = {stall_f1, stall_d1, stall_e1, flush_d1, flush_e1, flush_m1, mdu_done1};

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.REG_ADDR_W(RW), .NUM_SRC(NS), .MDU_LATENCY(4), .CNT_W(CW)) u_dut (
    .clk(clk), .rst(rst),
    .src_reg_id(src_reg_id), .src_valid_id(src_valid_id), .src_reg_ex(src_reg_ex),
    .reg_dest_ex(reg_dest_ex), .mem_read_ex(mem_read_ex), .mdu_start_ex(mdu_start_ex),
    .pc_src_ex(pc_src_ex), .reg_dest_mem(reg_dest_mem), .reg_dest_wb(reg_dest_wb),
    .reg_write_mem(reg_write_mem), .reg_write_wb(reg_write_wb),
    .forward_sel(forward_sel), .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e),
    .flush_d(flush_d), .flush_e(flush_e), .flush_m(flush_m), .mdu_done(mdu_done),
    .stall_cycles(stall_cycles), .redirect_count(redirect_count)
  );

  hazard_ctrl #(.REG_ADDR_W(RW), .NUM_SRC(NS), .MDU_LATENCY(1), .CNT_W(CW)) u_dut1 (
    .clk(clk), .rst(rst),
    .src_reg_id(src_reg_id), .src_valid_id(src_valid_id), .src_reg_ex(src_reg_ex),
    .reg_dest_ex(reg_dest_ex), .mem_read_ex(mem_read_ex), .mdu_start_ex(mdu_start_ex),
    .pc_src_ex(pc_src_ex), .reg_dest_mem(reg_dest_mem), .reg_dest_wb(reg_dest_wb),
    .reg_write_mem(reg_write_mem), .reg_write_wb(reg_write_wb),
    .forward_sel(forward_sel1), .stall_f(stall_f1), .stall_d(stall_d1), .stall_e(stall_e1),
    .flush_d(flush_d1), .flush_e(flush_e1), .flush_m(flush_m1), .mdu_done(mdu_done1),
    .stall_cycles(stall_cycles1), .redirect_count(redirect_count1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  task automatic clear_inputs();
    src_reg_id    = '0;
    src_valid_id  = '0;
    src_reg_ex    = '0;
    reg_dest_ex   = '0;
    mem_read_ex   = 1'b0;
    mdu_start_ex  = 1'b0;
    pc_src_ex     = 1'b0;
    reg_dest_mem  = '0;
    reg_dest_wb   = '0;
    reg_write_mem = 1'b0;
    reg_write_wb  = 1'b0;
  endtask

  // advance to just after the next rising edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_load_use();
    mem_read_ex  = 1'b1;
    reg_dest_ex  = 5'd7;
    src_reg_id   = {5'd7, 5'd2};
    src_valid_id = 2'b11;
  endtask

  initial begin
    // Reset with every hazard source active: outputs must stay quiet.
    clear_inputs();
    rst           = 1'b1;
    mdu_start_ex  = 1'b1;
    pc_src_ex     = 1'b1;
    src_reg_ex    = {5'd3, 5'd5};
    reg_dest_mem  = 5'd5;
    reg_write_mem = 1'b1;
    @(negedge clk);
    check("rst_ctl", 32'(ctl), 32'h0);
    check("rst_fwd", 32'(forward_sel), 32'h0);
    check("rst_ctl_lat1", 32'(ctl1), 32'h0);
    check("rst_stall_cnt", 32'(stall_cycles), 32'h0);
    cyc();
    rst = 1'b0;
    clear_inputs();

    // Forwarding
    src_reg_ex = {5'd3, 5'd5}; reg_dest_mem = 5'd5; reg_dest_wb = 5'd5;
    reg_write_mem = 1'b1; reg_write_wb = 1'b1;
    @(negedge clk); check("fwd_mem_wins", 32'(forward_sel), 32'b0010);
    cyc();
    reg_write_mem = 1'b0;
    @(negedge clk); check("fwd_wb", 32'(forward_sel), 32'b0001);
    cyc();
    src_reg_ex = {5'd3, 5'd0}; reg_dest_mem = 5'd0; reg_dest_wb = 5'd0; reg_write_mem = 1'b1;
    @(negedge clk); check("fwd_x0", 32'(forward_sel), 32'b0000);
    cyc();
    src_reg_ex = {5'd9, 5'd4}; reg_dest_mem = 5'd9; reg_dest_wb = 5'd9; reg_write_mem = 1'b0;
    @(negedge clk); check("fwd_slot1_wb", 32'(forward_sel), 32'b0100);
    cyc();
    clear_inputs();

    // Load-use
    set_load_use();
    @(negedge clk); check("lu_hit", 32'(ctl), 32'b1100100);
    cyc();
    src_valid_id = 2'b01;
    @(negedge clk); check("lu_invalid_slot", 32'(ctl), 32'b0000000);
    cyc();
    reg_dest_ex = 5'd0; src_reg_id = {5'd0, 5'd0}; src_valid_id = 2'b11;
    @(negedge clk); check("lu_x0", 32'(ctl), 32'b0000000);
    cyc();

    // Redirect beats load-use
    set_load_use();
    pc_src_ex = 1'b1;
    @(negedge clk); check("redir_over_lu", 32'(ctl), 32'b0001100);
    cyc();
    clear_inputs();

    // MDU op, latency 4, start held; redirect+load-use in cycle 1 ignored
    mdu_start_ex = 1'b1;
    @(negedge clk); check("mdu_c0", 32'(ctl), 32'b1110010);
    check("lat1_done", 32'(ctl1), 32'b0000001);
    cyc();
    set_load_use(); pc_src_ex = 1'b1;
    @(negedge clk); check("mdu_c1_prio", 32'(ctl), 32'b1110010);
    cyc();
    clear_inputs(); mdu_start_ex = 1'b1;
    @(negedge clk); check("mdu_c2", 32'(ctl), 32'b1110010);
    cyc();
    @(negedge clk); check("mdu_c3_done", 32'(ctl), 32'b0000001);
    cyc();
    @(negedge clk); check("mdu_b2b_c0", 32'(ctl), 32'b1110010);
    cyc();
    // Reset during BUSY cycle 1
    rst = 1'b1;
    @(negedge clk); check("mdu_rst_ctl", 32'(ctl), 32'h0);
    cyc();
    rst = 1'b0; mdu_start_ex = 1'b0;
    @(negedge clk);
    check("post_rst_idle", 32'(ctl), 32'h0);
    check("lat1_idle", 32'(ctl1), 32'h0);
    check("post_rst_stall_cnt", 32'(stall_cycles), 32'h0);
    check("post_rst_redir_cnt", 32'(redirect_count), 32'h0);
    cyc();

    // Performance counters: 20 load-use stall cycles, then one redirect
    set_load_use();
    for (int i = 0; i < 10; i++) cyc();
    @(negedge clk); check("stall_cnt_10", 32'(stall_cycles), EXP_STALL10);
    for (int i = 0; i < 10; i++) cyc();
    pc_src_ex = 1'b1;
    cyc();
    clear_inputs();
    @(negedge clk);
    check("stall_cnt_sat", 32'(stall_cycles), EXP_STALL);
    check("redir_cnt", 32'(redirect_count), EXP_REDIR);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
